dec_fpr_ctl_mp: RTL



---
 rtl/dec_fpr_ctl_mp.sv | 106 ++++++++++
 1 files changed

// File: rtl/dec_fpr_ctl_mp.sv
// Multi-port register file with two prioritised write ports, an optional write-to-read bypass,
// an optional hardwired zero register and a per-register busy scoreboard.
module dec_fpr_ctl_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rden,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wen0,
  input  logic [AW-1:0]        waddr0,
  input  logic [XLEN-1:0]      wd0,
  input  logic                 wen1,
  input  logic [AW-1:0]        waddr1,
  input  logic [XLEN-1:0]      wd1,
  input  logic                 busy_set,
  input  logic [AW-1:0]        busy_addr,
  output logic [DEPTH-1:0]     busy_vec,
  input  logic                 scan_mode
);

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_wv0;
  logic             w_wv1;
  logic             w_wr1;
  logic             w_bset;
  logic             w_unused;

  // A register is addressable unless it lies past DEPTH or is the hardwired zero register.
  function automatic logic addrValid(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wv0    = wen0 && addrValid(waddr0);
  assign w_wv1    = wen1 && addrValid(waddr1);
  assign w_wr1    = w_wv1 && !(w_wv0 && (waddr0 == waddr1));
  assign w_bset   = busy_set && addrValid(busy_addr);
  assign w_unused = scan_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr1) begin
        r_mem[waddr1] <= wd1;
      end
      if (w_wv0) begin
        r_mem[waddr0] <= wd0;
      end
    end
  end

  // Retiring writes clear their bit; a fresh issue to the same register overrides the clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int a = 0; a < DEPTH; a++) begin
      if ((w_wv0 && (waddr0 == AW'(a))) || (w_wv1 && (waddr1 == AW'(a)))) begin
        w_busy_nxt[a] = 1'b0;
      end
    end
    if (w_bset) begin
      w_busy_nxt[busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_ok;
    logic          w_hit0;
    logic          w_hit1;

    assign w_addr = raddr[p*AW +: AW];
    assign w_ok   = rden[p] && addrValid(w_addr);
    assign w_hit0 = (BYPASS != 0) && w_wv0 && (waddr0 == w_addr);
    assign w_hit1 = (BYPASS != 0) && w_wv1 && (waddr1 == w_addr);

    // Forwarded data is already available, so a bypassed read never reports busy.
    assign rd[p*XLEN +: XLEN] = (rst || !w_ok) ? '0 :
                                w_hit0         ? wd0 :
                                w_hit1         ? wd1 :
                                r_mem[w_addr];
    assign rd_busy[p] = !rst && w_ok && !w_hit0 && !w_hit1 && r_busy[w_addr];
  end

endmodule
